// File: rtl/mult_seq.sv
// mult_seq: 16x16 shift-add multiply sequencer that stalls execute while it runs.
// Optional early termination on an exhausted multiplier: define MULT_EARLY_TERM_EN.
module mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic        signed_op,
  input  logic        flush,
  output logic [15:0] result_lo,
  output logic [15:0] result_hi,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [3:0]  cnt;
  logic        neg;

  logic [15:0] mag_a;
  logic [15:0] mag_b;
  logic [31:0] acc_sum;
  logic        run_exit;

  // Magnitudes of signed operands; 0x8000 negates to itself and is used as unsigned.
  always_comb begin
    mag_a = (signed_op && opa[15]) ? (~opa + 16'd1) : opa;
    mag_b = (signed_op && opb[15]) ? (~opb + 16'd1) : opb;
  end

  always_comb begin
    acc_sum = mplier[0] ? (acc + mcand) : acc;
`ifdef MULT_EARLY_TERM_EN
    run_exit = (cnt == 4'd15) || (mplier[15:1] == 15'd0);
`else
    run_exit = (cnt == 4'd15);
`endif
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = start & ~done & ~flush;

  // A flush in RUN abandons the operation without touching the result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 32'd0;
      mcand     <= 32'd0;
      mplier    <= 16'd0;
      cnt       <= 4'd0;
      neg       <= 1'b0;
      result_lo <= 16'd0;
      result_hi <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            state  <= RUN;
            acc    <= 32'd0;
            mcand  <= {16'd0, mag_a};
            mplier <= mag_b;
            neg    <= signed_op & (opa[15] ^ opb[15]);
            cnt    <= 4'd0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (run_exit) begin
              state                  <= DONE;
              {result_hi, result_lo} <= neg ? (~acc_sum + 32'd1) : acc_sum;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq; a scoreboard queue holds expected products
// and latencies, and a monitor pops and compares them whenever done is presented.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        signed_op;
  logic        flush;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        busy;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [31:0] prod;
    int          issue;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mult_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opa       (opa),
    .opb       (opb),
    .signed_op (signed_op),
    .flush     (flush),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .busy      (busy),
    .done      (done),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle_cnt);
    end
  endtask

  // Cycle (counted from the request cycle) in which done is expected.
  function automatic int exp_latency(input logic [15:0] b, input logic s);
    logic [15:0] m;
    int          hi;
    m  = (s && b[15]) ? (~b + 16'd1) : b;
    hi = 0;
    for (int i = 0; i < 16; i++) if (m[i]) hi = i;
`ifdef MULT_EARLY_TERM_EN
    return hi + 2;
`else
    return (hi >= 0) ? 17 : 0;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cycle_cnt);
      end else begin
        e = sb_q.pop_front();
        check_output("product", {result_hi, result_lo}, e.prod);
        check_output("done_cycle", 32'(cycle_cnt - e.issue), 32'(e.lat));
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic s, input logic [31:0] prod);
    int lat;
    int n_stall;
    bit seen;
    @(negedge clk);
    opa       = a;
    opb       = b;
    signed_op = s;
    start     = 1'b1;
    lat       = exp_latency(b, s);
    sb_q.push_back('{prod, cycle_cnt, lat});
    n_stall = 0;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (done) begin
        seen = 1'b1;
        check_output("stall_in_done", 32'(stall), 32'd0);
      end else begin
        if (stall) n_stall++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done in 40 cycles, expected done in cycle %0d", lat);
      void'(sb_q.pop_back());
    end
    check_output("stall_cycles", 32'(n_stall), 32'(lat));
    @(negedge clk);
    start = 1'b0;
    #1;
    check_output("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    opa       = 16'd0;
    opb       = 16'd0;
    signed_op = 1'b0;
    #1;
    check_output("reset_outputs", {result_hi, result_lo}, 32'd0);
    check_output("reset_busy_done", {30'd0, busy, done}, 32'd0);
    start = 1'b1;
    #1;
    check_output("stall_in_reset", 32'(stall), 32'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    apply_stimulus(16'd3,     16'd5,     1'b0, 32'h0000_000F);
    apply_stimulus(16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE_0001);
    apply_stimulus(16'hFFFF,  16'hFFFF,  1'b1, 32'h0000_0001);
    apply_stimulus(16'hFFFE,  16'd7,     1'b1, 32'hFFFF_FFF2);
    apply_stimulus(16'h8000,  16'h8000,  1'b1, 32'h4000_0000);
    apply_stimulus(16'd5,     16'hFFFD,  1'b1, 32'hFFFF_FFF1);

    // Flush in cycle 5 of a request: no done, results untouched.
    @(negedge clk);
    opa       = 16'd3;
`ifdef MULT_EARLY_TERM_EN
    opb       = 16'h4005;
`else
    opb       = 16'd5;
`endif
    signed_op = 1'b0;
    start     = 1'b1;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    #1;
    check_output("busy_before_flush", 32'(busy), 32'd1);
    check_output("stall_with_flush", 32'(stall), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    #1;
    check_output("busy_after_flush", 32'(busy), 32'd0);
    check_output("result_hold_flush", {result_hi, result_lo}, 32'hFFFF_FFF1);
    repeat (20) @(negedge clk);
    apply_stimulus(16'd2, 16'd2, 1'b0, 32'h0000_0004);

    // Asynchronous reset in cycle 8 of a request.
    @(negedge clk);
    opa       = 16'h1234;
    opb       = 16'h5678;
    signed_op = 1'b0;
    start     = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    check_output("busy_before_reset", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_output("async_reset_busy_done", {30'd0, busy, done}, 32'd0);
    check_output("async_reset_result", {result_hi, result_lo}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(16'd6, 16'd7, 1'b0, 32'h0000_002A);

    apply_stimulus(16'd9,     16'd1,     1'b0, 32'h0000_0009);
    apply_stimulus(16'd9,     16'h0100,  1'b0, 32'h0000_0900);
    apply_stimulus(16'h1234,  16'd0,     1'b0, 32'h0000_0000);

    repeat (5) @(negedge clk);
    check_output("queue_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Multi-cycle 16x16 multiply sequencer for the execute stage. It accepts a multiply request from decode/execute control and runs a shift-add multiplication over up to 16 cycles. While it runs, it holds the pipeline with `stall` and then presents a registered 32-bit product for one `done` cycle. It sits beside the single-cycle ALU and owns its own datapath registers; execute muxes `result_lo` onto `alu_out` when `done` is high.

## Interface
Parameters:
- none (operand width fixed at 16 to match the ALU datapath)

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: multiply request. It is held high, with stable operands, for as long as `stall` is high.
- `opa` in 16: multiplicand, from `asrc`.
- `opb` in 16: multiplier, from `bsrc`.
- `signed_op` in 1: 1 means the operands are two's complement; 0 means unsigned.
- `flush` in 1: branch/jump squash of the instruction currently in execute.
- `result_lo` out 16: product bits [15:0], registered.
- `result_hi` out 16: product bits [31:16], registered.
- `busy` out 1: high in RUN.
- `done` out 1: high for exactly one cycle, in DONE.
- `stall` out 1: combinational, `start & ~done & ~flush`.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- **IDLE**
  - If `start & ~flush` on an edge: go to RUN.
  - On that same edge, load the 32-bit accumulator with 0.
  - Load the multiplicand register (32-bit) with |opa|, zero-extended.
  - Load the multiplier register (16-bit) with |opb|.
  - Record `neg = signed_op & (opa[15] ^ opb[15])`.
  - Clear the 4-bit iteration counter.
  - Magnitude is the two's complement negate when `signed_op` and bit 15 are set. 0x8000 yields magnitude 0x8000, treated as unsigned.
- **RUN**, each cycle:
  - If multiplier bit 0 is set, add the multiplicand to the accumulator (32-bit, carry out discarded).
  - Shift the multiplicand left by 1 and the multiplier right by 1 (logical).
  - Increment the counter.
  - Exit to DONE on the edge where the counter was 15.
  - On the exit edge, load `{result_hi,result_lo}` with the final accumulator, or its 32-bit two's complement negate if `neg`.
- **DONE**
  - `done`=1 and `stall`=0, so the pipeline advances.
  - Go to IDLE unconditionally on the next edge.
  - The `start` still high in DONE belongs to the finished instruction and is ignored.
- **Flush**
  - `flush` high in RUN forces IDLE on the next edge. The result registers are not updated and `done` is never asserted for that operation.
  - `flush` high in DONE has no effect: the state still goes to IDLE.
  - `flush` and `start` together in IDLE: no accept.
- Result registers hold their value until the next RUN->DONE transition.
- `busy` = (state==RUN). `done` = (state==DONE).

## Timing
- Reset values:
  - state IDLE.
  - `result_lo`/`result_hi` = 0x0000.
  - `busy` = 0, `done` = 0.
  - Internal registers all 0.
  - `stall` follows `start` combinationally, even during reset.
- Latency without early termination:
  - Accept edge at the end of cycle 0.
  - RUN in cycles 1-16.
  - DONE (`done`=1) in cycle 17.
  - `stall` is high in cycles 0-16.
- Back-to-back: a new `start` is first sampled in the IDLE cycle after DONE, so the minimum issue interval is 18 cycles (fixed latency).
- Reset asserted mid-RUN or in DONE: immediate return to IDLE and cleared outputs, with no `done` pulse.

## Configuration
- `MULT_EARLY_TERM_EN`
  - **Defined:** RUN also exits to DONE on any edge where the post-shift multiplier register is 0.
    - RUN length = index of the highest set bit of |opb| + 1, minimum 1 cycle (also for opb=0).
    - `done` arrives in cycle 1+RUN length+... i.e. cycle (RUN length + 1).
    - The product is identical to the non-early-termination product.
  - **Not defined:** fixed 16-cycle RUN, as above.

## Test plan
- Unsigned: `opa`=3, `opb`=5, `signed_op`=0, `start` held.
  - Required: `done` high in cycle 17 only.
  - `result_hi`:`result_lo` = 0x0000:0x000F.
  - `stall` high cycles 0-16.
- Unsigned: `opa`=0xFFFF, `opb`=0xFFFF, `signed_op`=0.
  - Required: 0xFFFE:0x0001.
  - Then `signed_op`=1, same operands: required 0x0000:0x0001.
- Signed: `opa`=0xFFFE (-2), `opb`=7.
  - Required: 0xFFFF:0xFFF2.
  - Then `opa`=`opb`=0x8000 signed: required 0x4000:0x0000.
- Flush mid-operation: `start` 3x5, `flush` pulsed in cycle 5.
  - Required: IDLE in cycle 6, `done` never high, results keep their previous value.
  - A new `start` of 2x2 then completes with 0x0000:0x0004.
- Reset mid-operation: `rst` asserted asynchronously in cycle 8 of a RUN.
  - Required: `busy`/`done`/results go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh 6x7 returns 0x0000:0x002A.
- `MULT_EARLY_TERM_EN` defined: `opa`=9, `opb`=1.
  - Required: RUN for 1 cycle, `done` in cycle 2, result 0x0000:0x0009.
  - `opb`=0x0100 gives `done` in cycle 10, and the same product as with the macro undefined.
